// File: rtl/case_4_acc_stage_if.sv
// Handshake bundle for the accumulation stage: block start, product
// stream in, saturated result out.
interface case_4_acc_stage_if #(
    parameter int unsigned DIN_WIDTH = 9,
    parameter int unsigned ACC_WIDTH = 18,
    parameter int unsigned LEN_WIDTH = 8
);
    logic                        start;
    logic [LEN_WIDTH-1:0]        len;
    logic signed [DIN_WIDTH-1:0] din;
    logic                        din_valid;
    logic                        din_ready;
    logic signed [ACC_WIDTH-1:0] dout;
    logic                        dout_valid;
    logic                        dout_ready;
    logic                        ovf;
    logic                        busy;

    // Producer/consumer side (drives commands and data, takes results)
    modport master (
        output start, len, din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, ovf, busy
    );

    // Accumulator side
    modport slave (
        input  start, len, din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, ovf, busy
    );
endinterface

// File: rtl/case_4_acc_stage.sv
// Block accumulator: sums LEN signed products with per-step saturation,
// then presents the sum and a sticky overflow flag until taken downstream.
module case_4_acc_stage #(
    parameter int unsigned DIN_WIDTH = 9,
    parameter int unsigned ACC_WIDTH = 18,
    parameter int unsigned LEN_WIDTH = 8
) (
    input logic            ap_clk,
    input logic            ap_rst_n,
    case_4_acc_stage_if.slave bus
);
    localparam int unsigned SUM_W = ACC_WIDTH + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [1:0]                  state_q, state_d;
    logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        sticky_q, sticky_d;
    logic signed [ACC_WIDTH-1:0] dout_q, dout_d;
    logic                        dout_valid_q, dout_valid_d;
    logic                        ovf_q, ovf_d;
    logic                        busy_q, busy_d;

    logic signed [DIN_WIDTH-1:0] din_s;
    logic signed [SUM_W-1:0]     sum;
    logic signed [ACC_WIDTH-1:0] sat_val;
    logic                        sat_hit;

    assign din_s = bus.din;

    // One guard bit of headroom; a guard/sign disagreement means the add left range
    always_comb begin
        sum     = SUM_W'(acc_q) + SUM_W'(din_s);
        sat_hit = 1'b0;
        sat_val = sum[ACC_WIDTH-1:0];
        if (sum[SUM_W-1] != sum[SUM_W-2]) begin
            sat_hit = 1'b1;
            sat_val = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        sticky_d     = sticky_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    if (bus.len != '0) begin
                        cnt_d   = bus.len;
                        state_d = ST_ACC;
                    end else begin
                        // Empty block: publish a zero result straight away
                        cnt_d        = '0;
                        state_d      = ST_OUT;
                        dout_d       = '0;
                        dout_valid_d = 1'b1;
                        ovf_d        = 1'b0;
                    end
                end
            end
            ST_ACC: begin
                if (bus.din_valid) begin
                    acc_d    = sat_val;
                    sticky_d = sticky_q | sat_hit;
                    cnt_d    = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        // Last beat: result lands on dout at the same edge
                        state_d      = ST_OUT;
                        dout_d       = sat_val;
                        dout_valid_d = 1'b1;
                        ovf_d        = sticky_q | sat_hit;
                    end
                end
            end
            ST_OUT: begin
                if (bus.dout_ready) begin
                    state_d      = ST_IDLE;
                    dout_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                dout_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            sticky_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            sticky_q     <= sticky_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
        end
    end

    // din_ready follows state alone so upstream never sees a valid->ready path
    assign bus.din_ready  = (state_q == ST_ACC);
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.ovf        = ovf_q;
    assign bus.busy       = busy_q;
endmodule
